miner_feeder: RTL and testbench

Job-side driver for the miner core: receives a header blob from the host into a 250-word buffer, then runs repeated hash attempts. For each attempt it pulses the miner's update strobe, serves header words on the miner's word-request strobe, and waits for the result. The nonce is incremented after every miss until a hit, an iteration limit or a stop request. It sits between the host register/stream interface and one miner instance, on the same clock.

---
 rtl/miner_pkg.sv | 26 ++
 rtl/header_buf.sv | 23 ++
 rtl/miner_feeder.sv | 177 +++++++++++++++++
 tb/tb_miner_feeder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// Shared types and constants for the miner job feeder.
package miner_pkg;

  localparam int unsigned NONCE_BYTE_LEN   = 24;
  localparam int unsigned MAX_HEADER_BYTES = 1000;
  localparam int unsigned BUF_WORDS        = 250;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StFound,
    StDone
  } feeder_state_t;

  typedef logic [191:0] nonce_t;

  // Header length in bytes rounded up to whole 32-bit words.
  function automatic logic [8:0] header_words(input logic [9:0] bytes);
    logic [10:0] sum;
    sum = {1'b0, bytes} + 11'd3;
    return sum[10:2];
  endfunction

endpackage

// File: rtl/header_buf.sv
// Header word buffer: one synchronous write port, one asynchronous read port.
module header_buf #(
  parameter int unsigned Depth = 250
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [7:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  raddr_i,
  output logic [31:0] rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/miner_feeder.sv
// Job-side driver for one miner core: buffers the header, issues attempts, steps the nonce.
module miner_feeder
  import miner_pkg::*;
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Wr_I,
  input  logic [7:0]   WrAddr_I,
  input  logic [31:0]  WrData_I,
  input  logic [9:0]   HeaderBytes_I,
  input  logic [191:0] NonceStart_I,
  input  logic [31:0]  MaxIter_I,
  input  logic         Start_I,
  input  logic         Stop_I,
  output logic         Update_O,
  output logic [31:0]  Msg_O,
  output logic [10:0]  ByteNum_O,
  output logic [191:0] Nonce_O,
  input  logic         Next_I,
  input  logic         Rdy_I,
  input  logic         Vld_I,
  input  logic [255:0] Hash_I,
  output logic         Busy_O,
  output logic         Found_O,
  output logic         Done_O,
  output logic [191:0] FoundNonce_O,
  output logic [255:0] FoundHash_O,
  output logic [31:0]  IterCnt_O
);

  feeder_state_t state_q, state_d;
  logic [7:0]    rd_ptr_q, rd_ptr_d;
  logic [8:0]    words_q, words_d;
  logic [10:0]   byte_num_q, byte_num_d;
  nonce_t        nonce_q, nonce_d;
  logic [31:0]   max_iter_q, max_iter_d;
  logic [31:0]   iter_q, iter_d;
  logic          vld_q, vld_d;
  logic [255:0]  hash_q, hash_d;
  logic          found_q, found_d;
  logic          done_q, done_d;
  nonce_t        found_nonce_q, found_nonce_d;
  logic [255:0]  found_hash_q, found_hash_d;

  logic          busy;
  logic          ptr_in_range;
  logic          buf_we;
  logic [31:0]   buf_rdata;
  logic [31:0]   iter_inc;

  assign busy         = (state_q == StIssue) || (state_q == StWait) || (state_q == StCheck);
  assign ptr_in_range = ({1'b0, rd_ptr_q} < words_q);
  assign buf_we       = Wr_I && !busy && (WrAddr_I < 8'(BUF_WORDS));
  assign iter_inc     = iter_q + 32'd1;

  header_buf #(
    .Depth (BUF_WORDS)
  ) u_header_buf (
    .clk_i   (Clk),
    .we_i    (buf_we),
    .waddr_i (WrAddr_I),
    .wdata_i (WrData_I),
    .raddr_i (rd_ptr_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    words_d       = words_q;
    byte_num_d    = byte_num_q;
    nonce_d       = nonce_q;
    max_iter_d    = max_iter_q;
    iter_d        = iter_q;
    vld_d         = vld_q;
    hash_d        = hash_q;
    found_d       = found_q;
    done_d        = done_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;

    // Stop overrides every other action, including a coincident Start.
    if (Stop_I) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StFound, StDone: begin
          if (Start_I) begin
            words_d    = header_words(HeaderBytes_I);
            byte_num_d = {1'b0, HeaderBytes_I} + 11'(NONCE_BYTE_LEN);
            nonce_d    = NonceStart_I;
            max_iter_d = MaxIter_I;
            iter_d     = '0;
            found_d    = 1'b0;
            done_d     = 1'b0;
            state_d    = StIssue;
          end
        end
        StIssue: begin
          rd_ptr_d = '0;
          state_d  = StWait;
        end
        StWait: begin
          if (Next_I && ptr_in_range) begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
          if (Rdy_I) begin
            vld_d   = Vld_I;
            hash_d  = Hash_I;
            state_d = StCheck;
          end
        end
        StCheck: begin
          iter_d = iter_inc;
          if (vld_q) begin
            found_nonce_d = nonce_q;
            found_hash_d  = hash_q;
            found_d       = 1'b1;
            state_d       = StFound;
          end else if ((max_iter_q != '0) && (iter_inc == max_iter_q)) begin
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            nonce_d = nonce_q + 192'd1;
            state_d = StIssue;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= StIdle;
      rd_ptr_q      <= '0;
      words_q       <= '0;
      byte_num_q    <= '0;
      nonce_q       <= '0;
      max_iter_q    <= '0;
      iter_q        <= '0;
      vld_q         <= 1'b0;
      hash_q        <= '0;
      found_q       <= 1'b0;
      done_q        <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      words_q       <= words_d;
      byte_num_q    <= byte_num_d;
      nonce_q       <= nonce_d;
      max_iter_q    <= max_iter_d;
      iter_q        <= iter_d;
      vld_q         <= vld_d;
      hash_q        <= hash_d;
      found_q       <= found_d;
      done_q        <= done_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
    end
  end

  assign Update_O     = (state_q == StIssue);
  // Past the last header word the miner is fed zeros while still waiting.
  assign Msg_O        = ((state_q == StWait) && !ptr_in_range) ? 32'd0 : buf_rdata;
  assign ByteNum_O    = byte_num_q;
  assign Nonce_O      = nonce_q;
  assign Busy_O       = busy;
  assign Found_O      = found_q;
  assign Done_O       = done_q;
  assign FoundNonce_O = found_nonce_q;
  assign FoundHash_O  = found_hash_q;
  assign IterCnt_O    = iter_q;

endmodule

// File: tb/tb_miner_feeder.sv
// Self-checking bench for miner_feeder with a behavioural miner model.
module tb_miner_feeder;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         Wr_I;
  logic [7:0]   WrAddr_I;
  logic [31:0]  WrData_I;
  logic [9:0]   HeaderBytes_I;
  logic [191:0] NonceStart_I;
  logic [31:0]  MaxIter_I;
  logic         Start_I;
  logic         Stop_I;
  logic         Update_O;
  logic [31:0]  Msg_O;
  logic [10:0]  ByteNum_O;
  logic [191:0] Nonce_O;
  logic         Busy_O;
  logic         Found_O;
  logic         Done_O;
  logic [191:0] FoundNonce_O;
  logic [255:0] FoundHash_O;
  logic [31:0]  IterCnt_O;

  // Miner model state
  logic         m_rdy, m_vld, m_busy, m_next;
  logic [255:0] m_hash;
  int           m_lat_cnt, m_req, m_attempt, m_upd_cnt;
  int           m_lat, m_words, m_hit_at;
  logic [255:0] m_hit_hash;
  logic [31:0]  msg_log [8];
  logic [31:0]  msg_tail;
  logic [191:0] nonce_log [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  miner_feeder dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Wr_I          (Wr_I),
    .WrAddr_I      (WrAddr_I),
    .WrData_I      (WrData_I),
    .HeaderBytes_I (HeaderBytes_I),
    .NonceStart_I  (NonceStart_I),
    .MaxIter_I     (MaxIter_I),
    .Start_I       (Start_I),
    .Stop_I        (Stop_I),
    .Update_O      (Update_O),
    .Msg_O         (Msg_O),
    .ByteNum_O     (ByteNum_O),
    .Nonce_O       (Nonce_O),
    .Next_I        (m_next),
    .Rdy_I         (m_rdy),
    .Vld_I         (m_vld),
    .Hash_I        (m_hash),
    .Busy_O        (Busy_O),
    .Found_O       (Found_O),
    .Done_O        (Done_O),
    .FoundNonce_O  (FoundNonce_O),
    .FoundHash_O   (FoundHash_O),
    .IterCnt_O     (IterCnt_O)
  );

  // Miner: drops Rdy after Update, requests m_words words, answers after m_lat cycles.
  always @(posedge Clk) begin
    if (Rst) begin
      m_rdy     <= 1'b1;
      m_vld     <= 1'b0;
      m_hash    <= '0;
      m_busy    <= 1'b0;
      m_next    <= 1'b0;
      m_req     <= 0;
      m_lat_cnt <= 0;
      m_attempt <= 0;
      m_upd_cnt <= 0;
    end else begin
      if (Start_I && !Stop_I && !Busy_O) begin
        m_attempt <= 0;
        m_upd_cnt <= 0;
      end
      if (Update_O) begin
        m_rdy     <= 1'b0;
        m_vld     <= 1'b0;
        m_busy    <= 1'b1;
        m_next    <= 1'b0;
        m_req     <= 0;
        m_lat_cnt <= 0;
        m_attempt <= m_attempt + 1;
        m_upd_cnt <= m_upd_cnt + 1;
        if (m_attempt < 8) nonce_log[m_attempt] <= Nonce_O;
      end else if (m_busy) begin
        m_lat_cnt <= m_lat_cnt + 1;
        m_next    <= (m_lat_cnt < m_words);
        if (m_next) begin
          if (m_req < 8) msg_log[m_req] <= Msg_O;
          m_req <= m_req + 1;
        end else if (m_req == m_words) begin
          msg_tail <= Msg_O;
        end
        if (m_lat_cnt == m_lat) begin
          m_rdy  <= 1'b1;
          m_vld  <= (m_attempt == m_hit_at);
          m_hash <= m_hit_hash;
          m_busy <= 1'b0;
          m_next <= 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [191:0] nstart;
    logic [31:0]  max_iter;
    int           hit_at;
    logic [255:0] hash;
    logic [9:0]   hbytes;
    logic         exp_found;
    logic         exp_done;
    logic [31:0]  exp_iter;
    logic [191:0] exp_fnonce;
    logic [191:0] exp_last_nonce;
    logic [10:0]  exp_bytenum;
  } vec_t;

  vec_t vec [5];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [7:0] addr, input logic [31:0] data);
    Wr_I     = 1'b1;
    WrAddr_I = addr;
    WrData_I = data;
    tick();
    Wr_I     = 1'b0;
  endtask

  task automatic start_job(input logic [191:0] ns, input logic [31:0] mi, input logic [9:0] hb);
    NonceStart_I  = ns;
    MaxIter_I     = mi;
    HeaderBytes_I = hb;
    m_words       = (int'(hb) + 3) / 4;
    Start_I       = 1'b1;
    tick();
    Start_I       = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (Busy_O && n < 2000) begin
      tick();
      n++;
    end
    chk(name, {255'd0, Busy_O}, 256'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, {255'd0, Busy_O}, 256'd0);
    chk({tag, "_update"}, {255'd0, Update_O}, 256'd0);
    chk({tag, "_bytenum"}, {245'd0, ByteNum_O}, 256'd0);
    chk({tag, "_nonce"}, {64'd0, Nonce_O}, 256'd0);
    chk({tag, "_found"}, {255'd0, Found_O}, 256'd0);
    chk({tag, "_done"}, {255'd0, Done_O}, 256'd0);
    chk({tag, "_iter"}, {224'd0, IterCnt_O}, 256'd0);
    chk({tag, "_fnonce"}, {64'd0, FoundNonce_O}, 256'd0);
    chk({tag, "_fhash"}, FoundHash_O, 256'd0);
  endtask

  initial begin
    Rst = 1'b1; Wr_I = 1'b0; WrAddr_I = '0; WrData_I = '0;
    HeaderBytes_I = '0; NonceStart_I = '0; MaxIter_I = '0;
    Start_I = 1'b0; Stop_I = 1'b0;
    m_lat = 12; m_words = 0; m_hit_at = 0; m_hit_hash = '0;

    vec[0] = '{192'd5, 32'd3, 0, 256'h0, 10'd16, 1'b0, 1'b1, 32'd3, 192'd0, 192'd7, 11'd40};
    vec[1] = '{192'd10, 32'd0, 3, 256'hABCD, 10'd16, 1'b1, 1'b0, 32'd3, 192'd12, 192'd12, 11'd40};
    vec[2] = '{{192{1'b1}}, 32'd2, 0, 256'h0, 10'd5, 1'b0, 1'b1, 32'd2, 192'd0, 192'd0, 11'd29};
    vec[3] = '{192'd100, 32'd1, 1, 256'h1234, 10'd0, 1'b1, 1'b0, 32'd1, 192'd100, 192'd100, 11'd24};
    vec[4] = '{192'd7, 32'd5, 5, 256'h77, 10'd13, 1'b1, 1'b0, 32'd5, 192'd11, 192'd11, 11'd37};

    repeat (2) tick();
    chk_reset_vals("rst");
    Rst = 1'b0;
    tick();

    // Header streaming with show-ahead reads
    write_word(8'd0, 32'h11111111);
    write_word(8'd1, 32'h22222222);
    write_word(8'd2, 32'h33333333);
    write_word(8'd3, 32'h44444444);
    write_word(8'd250, 32'hBAD0BAD0);
    m_lat = 12; m_hit_at = 0;
    start_job(192'd0, 32'd1, 10'd16);
    chk("issue_update", {255'd0, Update_O}, 256'd1);
    chk("issue_busy", {255'd0, Busy_O}, 256'd1);
    chk("issue_bytenum", {245'd0, ByteNum_O}, 256'd40);
    tick();
    chk("wait_update_low", {255'd0, Update_O}, 256'd0);
    chk("wait_msg0", {224'd0, Msg_O}, 256'h11111111);
    wait_idle("stream_timeout");
    chk("msg_w0", {224'd0, msg_log[0]}, 256'h11111111);
    chk("msg_w1", {224'd0, msg_log[1]}, 256'h22222222);
    chk("msg_w2", {224'd0, msg_log[2]}, 256'h33333333);
    chk("msg_w3", {224'd0, msg_log[3]}, 256'h44444444);
    chk("msg_tail", {224'd0, msg_tail}, 256'd0);
    chk("stream_updates", 256'(m_upd_cnt), 256'd1);
    chk("stream_done", {255'd0, Done_O}, 256'd1);

    for (int i = 0; i < 5; i++) begin
      m_hit_at   = vec[i].hit_at;
      m_hit_hash = vec[i].hash;
      start_job(vec[i].nstart, vec[i].max_iter, vec[i].hbytes);
      wait_idle($sformatf("v%0d_timeout", i));
      chk($sformatf("v%0d_found", i), {255'd0, Found_O}, {255'd0, vec[i].exp_found});
      chk($sformatf("v%0d_done", i), {255'd0, Done_O}, {255'd0, vec[i].exp_done});
      chk($sformatf("v%0d_iter", i), {224'd0, IterCnt_O}, {224'd0, vec[i].exp_iter});
      chk($sformatf("v%0d_nonce", i), {64'd0, Nonce_O}, {64'd0, vec[i].exp_last_nonce});
      chk($sformatf("v%0d_bytenum", i), {245'd0, ByteNum_O}, {245'd0, vec[i].exp_bytenum});
      chk($sformatf("v%0d_updates", i), 256'(m_upd_cnt), {224'd0, vec[i].exp_iter});
      chk($sformatf("v%0d_first_nonce", i), {64'd0, nonce_log[0]}, {64'd0, vec[i].nstart});
      if (vec[i].exp_found) begin
        chk($sformatf("v%0d_fnonce", i), {64'd0, FoundNonce_O}, {64'd0, vec[i].exp_fnonce});
        chk($sformatf("v%0d_fhash", i), FoundHash_O, vec[i].hash);
      end
    end
    chk("nonce_seq_1", {64'd0, nonce_log[1]}, 256'd8);
    chk("nonce_seq_4", {64'd0, nonce_log[4]}, 256'd11);

    // Stop in FOUND keeps the result flags
    Stop_I = 1'b1;
    tick();
    Stop_I = 1'b0;
    chk("stop_found_kept", {255'd0, Found_O}, 256'd1);
    chk("stop_iter_kept", {224'd0, IterCnt_O}, 256'd5);

    // Stop mid-WAIT, then Start with Stop in the same cycle
    m_lat = 50; m_hit_at = 0;
    start_job(192'd0, 32'd0, 10'd16);
    repeat (4) tick();
    chk("midwait_busy", {255'd0, Busy_O}, 256'd1);
    write_word(8'd0, 32'hDEADBEEF);
    Stop_I = 1'b1;
    tick();
    Stop_I = 1'b0;
    chk("stop_busy", {255'd0, Busy_O}, 256'd0);
    chk("stop_iter", {224'd0, IterCnt_O}, 256'd0);
    Start_I = 1'b1; Stop_I = 1'b1;
    tick();
    Start_I = 1'b0; Stop_I = 1'b0;
    chk("startstop_busy", {255'd0, Busy_O}, 256'd0);
    chk("startstop_update", {255'd0, Update_O}, 256'd0);
    tick();
    chk("startstop_update2", {255'd0, Update_O}, 256'd0);
    m_lat = 12;
    start_job(192'd0, 32'd1, 10'd16);
    wait_idle("restart_timeout");
    chk("busy_write_dropped", {224'd0, msg_log[0]}, 256'h11111111);

    // Reset during WAIT, then a normal job
    m_hit_at = 1; m_hit_hash = 256'h55;
    start_job(192'd3, 32'd0, 10'd16);
    repeat (3) tick();
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk_reset_vals("wrst");
    chk("wrst_msg", {224'd0, Msg_O}, 256'h11111111);
    tick();
    start_job(192'd9, 32'd0, 10'd16);
    wait_idle("post_rst_timeout");
    chk("post_rst_found", {255'd0, Found_O}, 256'd1);
    chk("post_rst_fnonce", {64'd0, FoundNonce_O}, 256'd9);
    chk("post_rst_fhash", FoundHash_O, 256'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
